// File: rtl/accel_seq_ctrl.sv
// Frame sequencer: loads one frame from S_AXIS into the frame buffer, kicks the
// processing core, then drains the buffer to M_AXIS through a 2-entry output FIFO.
module accel_seq_ctrl #(
  parameter int NUM_WORDS = 576,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic                buf_wr_en,
  output logic [ADDR_W-1:0]   buf_wr_addr,
  output logic                proc_start,
  input  logic                proc_done,
  output logic                buf_rd_en,
  output logic [ADDR_W-1:0]   buf_rd_addr,
  input  logic [DATA_W-1:0]   buf_rd_data,
  output logic                m_axis_tvalid,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tstrb,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, PROC, DRAIN} state_e;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tready_q, tready_d;
  logic             pstart_q, pstart_d;
  // rd_vld: a buffer read was issued last cycle, its data is on buf_rd_data now
  logic             rd_vld_q, rd_vld_d;
  logic             rd_tag_q, rd_tag_d;
  beat_t [1:0]      fifo_q, fifo_d;
  logic             wp_q, wp_d, rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;

  logic             wr_beat, rd_issue, push, pop;
  logic [2:0]       occ;
  beat_t            head;

  assign head = fifo_q[rp_q];

  always_comb begin
    wr_beat  = (state_q == LOAD) && tready_q && s_axis_tvalid;
    pop      = (cnt_q != 2'd0) && m_axis_tready;
    push     = rd_vld_q;
    // Slots committed after this cycle: stored + arriving - leaving.
    occ      = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
    rd_issue = (state_q == DRAIN) && (rd_cnt_q < FRAME_LEN) && (occ < 3'd2);

    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    pstart_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      LOAD: begin
        if (wr_beat) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (s_axis_tlast != (wr_cnt_q == LAST_IDX)) err_d = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = PROC;
            pstart_d = 1'b1;
          end
        end
      end
      PROC: begin
        if (proc_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d == LOAD);
    if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
    rd_vld_d = rd_issue;
    rd_tag_d = rd_issue && (rd_cnt_q == LAST_IDX);

    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (push) begin
      fifo_d[wp_q].last = rd_tag_q;
      fifo_d[wp_q].data = buf_rd_data;
      wp_d              = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tready_q <= 1'b0;
      pstart_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= 1'b0;
      fifo_q   <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tready_q <= tready_d;
      pstart_q <= pstart_d;
      rd_vld_q <= rd_vld_d;
      rd_tag_q <= rd_tag_d;
      fifo_q   <= fifo_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_tlast     = err_q;
  assign s_axis_tready = tready_q;
  assign buf_wr_en     = wr_beat;
  assign buf_wr_addr   = wr_cnt_q[ADDR_W-1:0];
  assign proc_start    = pstart_q;
  assign buf_rd_en     = rd_issue;
  assign buf_rd_addr   = rd_cnt_q[ADDR_W-1:0];
  // Valid comes from the registered count only, so tready never reaches it.
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
  assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Scoreboard bench for accel_seq_ctrl: frame buffer and processing core are modelled
// here; the core XORs every word with KEY, so output beats must equal input ^ KEY.
module tb_accel_seq_ctrl;
  localparam int NW = 576;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam logic [31:0] KEY = 32'h5A5A_C3C3;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err_tlast;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic          proc_start;
  logic          proc_done = 1'b0;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tstrb;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;

  accel_seq_ctrl #(.NUM_WORDS(NW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .err_tlast(err_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .proc_start(proc_start), .proc_done(proc_done), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame buffer and processing core
  logic [31:0] mem [0:1023];
  logic [31:0] proc_key = '0;
  int          proc_delay = 10;
  int          pd_cyc = 0;

  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_addr] <= s_tdata;
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr] ^ proc_key;
  end

  always begin
    @(negedge clk);
    if (proc_start && rstn) begin
      proc_key = '0;
      if (proc_delay > 0) begin
        repeat (proc_delay) @(posedge clk);
        #1;
      end
      proc_done = 1'b1;
      pd_cyc    = cyc;
      proc_key  = KEY;
      @(posedge clk);
      #1 proc_done = 1'b0;
    end
  end

  // Scoreboard and monitor
  exp_t        sb[$];
  int          out_cnt = 0, wr_exp = 0, pstart_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic        prev_stall = 1'b0, prev_rstn = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rstn && start && !busy) begin
      out_cnt = 0; wr_exp = 0; pstart_cnt = 0;
    end
    if (rstn) begin
      if (buf_wr_en) begin
        chk("wr_addr", 64'(buf_wr_addr), 64'(wr_exp));
        wr_exp++;
      end
      if (proc_start) pstart_cnt++;
      if (prev_stall && prev_rstn) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'(1));
        chk("stall_data", 64'(m_axis_tdata), 64'(prev_data));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'({e.last, e.data}));
        end
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
    end
    prev_stall = rstn && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_rstn  = rstn;
  end

  // Output ready pattern: mode 0 = held high; mode 1 = toggling with a 20-cycle stall
  int   rdy_mode = 0;
  logic held = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (out_cnt == 0) held = 1'b0;
    if (rdy_mode == 0) m_axis_tready = 1'b1;
    else if (out_cnt >= 288 && !held) begin
      m_axis_tready = 1'b0;
      held = 1'b1;
      repeat (19) @(posedge clk);
    end else m_axis_tready = ~m_axis_tready;
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_flags_clear", 64'({done, err_tlast}), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [31:0] base, input bit gap, input int bad, input bit spur);
    int   i = 0, ph = 0, guard = 0;
    exp_t e;
    while (i < NW && guard < 4000) begin
      s_axis_tvalid = !(gap && (ph % 3 == 2));
      ph++;
      s_tdata      = base + 32'(i);
      s_axis_tlast = (i == NW - 1) || (i == bad);
      start        = spur && (i == 50);
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        e.last = (i == NW - 1);
        e.data = (base + 32'(i)) ^ KEY;
        sb.push_back(e);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    start         = 1'b0;
    chk("load_beats", 64'(i), 64'(NW));
  endtask

  task automatic wait_done(input bit spur);
    bit sent = 1'b0, ok = 1'b0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      @(posedge clk); #1;
      start = spur && !sent && (out_cnt >= 10);
      if (start) sent = 1'b1;
      @(negedge clk);
      ok = done;
    end
    start = 1'b0;
    chk("done_reached", 64'(ok), 64'(1));
  endtask

  task automatic check_frame(input bit exp_err, input bit tp);
    chk("busy_after", 64'(busy), 64'(0));
    chk("done_set", 64'(done), 64'(1));
    chk("err_tlast", 64'(err_tlast), 64'(exp_err));
    chk("out_beats", 64'(out_cnt), 64'(NW));
    chk("wr_beats", 64'(wr_exp), 64'(NW));
    chk("proc_pulses", 64'(pstart_cnt), 64'(1));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    if (tp) begin
      chk("throughput_span", 64'(last_cyc - first_cyc), 64'(NW - 1));
      chk("first_latency", 64'(first_cyc - pd_cyc), 64'(3));
    end
  endtask

  initial begin
    bit ok;
    int bad_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({busy, done, err_tlast, s_axis_tready, buf_wr_en, buf_rd_en,
                              proc_start, m_axis_tvalid, m_axis_tlast}), 64'(0));
    chk("tstrb", 64'(m_axis_tstrb), 64'(4'hF));
    @(posedge clk); #1 rstn = 1'b1;

    // Nominal frame, data = beat index
    rdy_mode = 0; proc_delay = 10;
    start_frame();
    send_frame(32'h0, 1'b0, -1, 1'b0);
    wait_done(1'b0);
    check_frame(1'b0, 1'b1);

    // Backpressure plus spurious starts in LOAD and DRAIN; done must clear on restart
    rdy_mode = 1; proc_delay = 5;
    start_frame();
    send_frame(32'h1000_0000, 1'b0, -1, 1'b1);
    wait_done(1'b1);
    check_frame(1'b0, 1'b0);
    bad_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || s_axis_tready || m_axis_tvalid) bad_cnt++;
    end
    chk("idle_no_restart", 64'(bad_cnt), 64'(0));
    chk("idle_proc_pulses", 64'(pstart_cnt), 64'(1));
    @(posedge clk); #1;

    // Gapped input with early TLAST; proc_done in the proc_start cycle
    rdy_mode = 0; proc_delay = 0;
    start_frame();
    send_frame(32'hABCD_0000, 1'b1, 100, 1'b0);
    wait_done(1'b0);
    check_frame(1'b1, 1'b1);

    // Reset mid-drain at output beat 300
    proc_delay = 3;
    start_frame();
    send_frame(32'h7700_0000, 1'b0, -1, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = (out_cnt >= 300);
    end
    chk("reach_beat300", 64'(ok), 64'(1));
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("reset_mid_drain", 64'({busy, done, err_tlast, s_axis_tready, buf_wr_en, buf_rd_en,
                                proc_start, m_axis_tvalid, m_axis_tlast}), 64'(0));
    chk("reset_tdata", 64'(m_axis_tdata), 64'(0));
    bad_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_axis_tvalid || busy || buf_rd_en) bad_cnt++;
    end
    chk("quiet_after_reset", 64'(bad_cnt), 64'(0));
    @(posedge clk); #1;

    // Fresh frame after reset
    proc_delay = 7;
    start_frame();
    send_frame(32'hC0DE_0100, 1'b0, -1, 1'b0);
    wait_done(1'b0);
    check_frame(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/accel_seq_ctrl.md
Name: accel_seq_ctrl

Overview:
- Frame sequencer for the image-editing accelerator.
- After a software start pulse from the AXI-lite control register, it:
  - accepts one frame of NUM_WORDS input words from the S_AXIS port into the frame buffer;
  - triggers the processing core;
  - streams the processed buffer out on M_AXIS with TLAST on the final beat;
  - reports busy/done/error back to the control register file.
- Sits between the AXI-lite register block, the stream ports, the frame buffer and the processing core.

Parameters:
- NUM_WORDS, 576, words per frame (four 8-bit pixels per word).
- DATA_W, 32, stream and buffer data width.
- ADDR_W, 10, frame-buffer address width; must satisfy 2^ADDR_W >= NUM_WORDS.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; control reg 0 written with bit0=1
- busy  out  1  high from accepted start until last output beat
- done  out  1  sticky; set on last output beat, cleared by next accepted start
- err_tlast  out  1  sticky TLAST-mismatch flag; cleared by next accepted start
- s_axis_tvalid  in  1  input stream valid
- s_axis_tready  out  1  input stream ready
- s_axis_tlast  in  1  input stream last
- buf_wr_en  out  1  frame-buffer write enable (data comes directly from s_axis_tdata)
- buf_wr_addr  out  ADDR_W  frame-buffer write address
- proc_start  out  1  one-cycle pulse to processing core
- proc_done  in  1  one-cycle pulse from processing core
- buf_rd_en  out  1  frame-buffer read enable
- buf_rd_addr  out  ADDR_W  frame-buffer read address
- buf_rd_data  in  DATA_W  read data, valid exactly 1 cycle after buf_rd_en
- m_axis_tvalid  out  1  output stream valid
- m_axis_tdata  out  DATA_W  output stream data
- m_axis_tstrb  out  DATA_W/8  always all ones
- m_axis_tlast  out  1  high on beat NUM_WORDS-1 only
- m_axis_tready  in  1  output stream ready

Behaviour:
- Reset (rstn=0 at posedge clk):
  - FSM returns to IDLE; counters and output FIFO clear.
  - busy, done, err_tlast, s_axis_tready, buf_wr_en, buf_rd_en, proc_start, m_axis_tvalid and m_axis_tlast are 0.
  - Applies mid-frame too: the partial frame is abandoned and no further beats are emitted.
- FSM states: IDLE, LOAD, PROC, DRAIN.
- IDLE:
  - start=1 -> LOAD; clear wr_cnt, done and err_tlast; busy=1 from the next cycle.
- LOAD:
  - s_axis_tready=1 (registered, asserted the cycle after entry).
  - Each cycle with tvalid&tready: buf_wr_en=1 (combinational), buf_wr_addr=wr_cnt, wr_cnt++.
  - Beat with wr_cnt=NUM_WORDS-1 -> PROC; tready drops the following cycle.
  - Termination is count-based only.
  - err_tlast sets if tlast=1 on any beat other than NUM_WORDS-1, or tlast=0 on beat NUM_WORDS-1.
  - An early tlast does not end LOAD.
- PROC:
  - proc_start is a single-cycle pulse on the first cycle of PROC.
  - Stay until proc_done=1 -> DRAIN.
  - A proc_done arriving in the same cycle as proc_start is accepted.
- DRAIN:
  - 2-entry output FIFO feeds m_axis.
  - Issue buf_rd_en with rd_addr++ while rd_addr<NUM_WORDS and (occupancy + in-flight − pop_this_cycle) < 2.
  - Must sustain 1 beat/cycle when m_axis_tready is held high.
  - First-beat latency: m_axis_tvalid rises 2 cycles after DRAIN entry.
  - m_axis_tvalid/tdata stay stable while tready=0 (AXIS rule).
  - tlast is tagged on the entry read from address NUM_WORDS-1.
  - Beat NUM_WORDS-1 accepted -> done=1, busy=0, IDLE on the next cycle.
- start while busy: ignored, no effect on state or flags.
- start in the same cycle done is being set: ignored; must be re-issued in IDLE.
- Widths: counters are ADDR_W+1 bits internally and never wrap within a frame.
- No combinational path from m_axis_tready to m_axis_tvalid.

Test Plan:
- Nominal frame:
  - start; 576 beats data=i, tvalid continuous, tlast on i=575; proc_done 10 cycles after proc_start; tready=1.
  - Expect: 576 buf writes, addr 0..575; one proc_start pulse; 576 output beats data=buf[i]; tlast only on beat 575; done=1, busy=0, err_tlast=0.
- Output backpressure:
  - tready toggles 1010… then is held low 20 cycles mid-frame.
  - Expect: no beat lost or duplicated; tdata stable while stalled; exactly 576 beats; tlast on the 576th.
- Input gaps plus TLAST error:
  - tvalid gapped every third cycle; tlast asserted on beat 100.
  - Expect: err_tlast=1; load still completes at 576 beats; frame processed and drained normally.
- Start handling:
  - start pulsed during LOAD and during DRAIN: ignored, single frame only.
  - Second start after done: done clears and a fresh frame runs.
- Reset mid-DRAIN:
  - rstn=0 for 1 cycle at output beat 300.
  - Expect: all outputs 0 next cycle; IDLE; no further m_axis_tvalid until a new start and full frame.
- Throughput:
  - tready=1 constantly.
  - Expect: 576 output beats in 576 consecutive cycles after the first tvalid.
